// File: rtl/fm_psum_acc_if.sv
// Psum beat input and final-sum output handshakes for fm_psum_acc.
// master drives beats and accepts sums; slave is the accumulator.
interface fm_psum_acc_if #(
  parameter int LANES  = 6,
  parameter int PSUM_W = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*PSUM_W-1:0]   in_data;
  logic                      in_last;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*PSUM_W-1:0]   out_data;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/fm_psum_acc.sv
// Row-level psum accumulator over 1 or 3 kernel-row passes with a one-entry output register.
// Optional macro PSUM_ACC_SAT_EN: saturating lane adds instead of wrapping.
module fm_psum_acc #(
  parameter int LANES  = 6,
  parameter int PSUM_W = 16,
  parameter int DEPTH  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_valid,
  input  logic        kernel_mode_i,
  output logic        busy,
  fm_psum_acc_if.slave bus,
  output logic        psum_almost_valid,
  output logic [1:0]  pass_idx,
  output logic        err_len
);
  localparam int DW = LANES * PSUM_W;
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {S_IDLE, S_RUN} state_e;
  state_e state_q, state_d;

  logic          kmode_q, kmode_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0]    pass_q, pass_d;
  logic [AW:0]   row_len_q, row_len_d;
  logic          err_q, err_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [DW-1:0] row_buf_q [DEPTH];

  logic          final_pass, accept, cfg_accept;
  logic [DW-1:0] rd_data, acc_data;
  logic [AW:0]   beat_cnt;

  function automatic logic [PSUM_W-1:0] lane_add(input logic [PSUM_W-1:0] a,
                                                 input logic [PSUM_W-1:0] b);
    logic signed [PSUM_W:0] s;
    s = $signed({a[PSUM_W-1], a}) + $signed({b[PSUM_W-1], b});
`ifdef PSUM_ACC_SAT_EN
    if (s[PSUM_W] != s[PSUM_W-1])
      lane_add = s[PSUM_W] ? {1'b1, {(PSUM_W-1){1'b0}}} : {1'b0, {(PSUM_W-1){1'b1}}};
    else
      lane_add = s[PSUM_W-1:0];
`else
    lane_add = s[PSUM_W-1:0];
`endif
  endfunction

  always_comb begin
    state_d = state_q;
    if (state_q == S_IDLE && cfg_valid) state_d = S_RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Row buffer reads asynchronously, so a row_len=1 write is visible to the next pass's read.
  always_comb begin
    busy              = (state_q == S_RUN);
    cfg_accept        = cfg_valid && (state_q == S_IDLE);
    final_pass        = kmode_q ? (pass_q == 2'd2) : (pass_q == 2'd0);
    bus.in_ready      = busy && (!final_pass || !out_valid_q || bus.out_ready);
    accept            = bus.in_valid && bus.in_ready;
    psum_almost_valid = accept && final_pass;
    rd_data           = row_buf_q[wr_ptr_q];
    beat_cnt          = {1'b0, wr_ptr_q} + (AW+1)'(1);
    acc_data          = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      acc_data[k*PSUM_W +: PSUM_W] = (pass_q == 2'd0) ? bus.in_data[k*PSUM_W +: PSUM_W]
        : lane_add(rd_data[k*PSUM_W +: PSUM_W], bus.in_data[k*PSUM_W +: PSUM_W]);
    end
  end

  always_comb begin
    kmode_d     = kmode_q;
    wr_ptr_d    = wr_ptr_q;
    pass_d      = pass_q;
    row_len_d   = row_len_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (cfg_accept) begin
      kmode_d   = kernel_mode_i;
      wr_ptr_d  = '0;
      pass_d    = '0;
      row_len_d = '0;
    end else if (accept) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (bus.in_last) begin
        wr_ptr_d = '0;
        pass_d   = final_pass ? 2'd0 : pass_q + 2'd1;
        if (pass_q == 2'd0)              row_len_d = beat_cnt;
        else if (beat_cnt != row_len_q)  err_d     = 1'b1;
      end else if (wr_ptr_q == AW'(DEPTH-1)) begin
        err_d = 1'b1;
      end
    end
    if (accept && final_pass) begin
      out_valid_d = 1'b1;
      out_data_d  = acc_data;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kmode_q     <= 1'b0;
      wr_ptr_q    <= '0;
      pass_q      <= '0;
      row_len_q   <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      kmode_q     <= kmode_d;
      wr_ptr_q    <= wr_ptr_d;
      pass_q      <= pass_d;
      row_len_q   <= row_len_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !final_pass) row_buf_q[wr_ptr_q] <= acc_data;
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign pass_idx      = pass_q;
  assign err_len       = err_q;
endmodule

// File: doc/fm_psum_acc.md
# fm_psum_acc

Row-level partial-sum accumulator that sits directly upstream of the feature-map guard-generation control. It takes 6-lane psum beats from the PE array and accumulates them across the kernel-row passes of one output row in an internal row buffer. It emits final sums through a one-entry output register. It produces the `psum_almost_valid` pulse on which the guard-gen control advances its w/h/c counters.

## Interface
Parameters:
- `LANES`, 6, psum lanes per beat (one column group).
- `PSUM_W`, 16, signed width per lane.
- `DEPTH`, 64, row-buffer entries (column groups per row); power of two.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_valid`  in  1  load configuration; accepted only when `busy`=0.
- `kernel_mode_i`  in  1  0: 1x1 kernel (1 pass per row); 1: 3x3 kernel (3 passes per row).
- `busy`  out  1  high from accepted `cfg_valid` until `rst`.
- `in_valid`  in  1  psum beat valid.
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`.
- `in_data`  in  LANES*PSUM_W  lane k at bits [k*PSUM_W +: PSUM_W].
- `in_last`  in  1  last column group of the current pass.
- `out_valid`  out  1  final sum valid.
- `out_ready`  in  1  downstream accept.
- `out_data`  out  LANES*PSUM_W  accumulated row-group sums.
- `psum_almost_valid`  out  1  one-cycle pulse; a final-pass beat was accepted this cycle.
- `pass_idx`  out  2  current pass, 0..2.
- `err_len`  out  1  sticky; pass length mismatch or buffer overflow.

## Operation
- Configuration:
  - `cfg_valid` with `busy`=0 latches `kernel_mode`, sets `busy`=1 and clears `wr_ptr`, `pass_idx`, `row_len`.
  - `cfg_valid` while `busy`=1 is ignored.
  - Beats are accepted only when `busy`=1.
- Pass count: `NPASS` = 3 if `kernel_mode`, else 1. The final pass is `pass_idx == NPASS-1`.
- Per accepted beat, at entry `buf[wr_ptr]`:
  - Pass 0 and not final: `buf` <= `in_data`.
  - Middle pass: `buf` <= lane-wise `buf + in_data`.
  - Final pass: `out_data` <= `buf + in_data`, or `in_data` alone when `NPASS`=1. `out_valid` <= 1. `buf` is not written.
- `wr_ptr` increments per accepted beat. On `in_last` it returns to 0 and `pass_idx` advances. After the final pass, `pass_idx` wraps to 0 for the next row.
- Row length:
  - The pass-0 `in_last` records `row_len` = `wr_ptr`+1.
  - A later pass whose `in_last` falls at a different count sets `err_len`. That pass completes anyway and `pass_idx` still advances.
- Overflow: a beat at `wr_ptr == DEPTH-1` without `in_last` wraps `wr_ptr` to 0 and sets `err_len`.
- Ready rule:
  - `in_ready` = `busy && (!final_pass || !out_valid || out_ready)`.
  - Non-final passes never stall.
- Output register:
  - `out_valid` clears on `out_ready` unless a new final beat loads in the same cycle; in that case it stays 1 and the data is replaced.
  - `out_data` is held stable while `out_valid && !out_ready`.
- `psum_almost_valid` = accepted beat && final pass, registered-free (combinational on the handshake). It leads `out_valid` by one cycle.

## Timing
- Reset values: `busy`=0, `in_ready`=0, `out_valid`=0, `out_data`=0, `psum_almost_valid`=0, `pass_idx`=0, `err_len`=0.
- Row-buffer contents are not reset.
- Latency: final-pass beat accepted in cycle t → `out_valid`=1 with its data in cycle t+1.
- Throughput: 1 beat/cycle when `out_ready`=1 is held.
- `rst` mid-row:
  - Discards all state, including a pending output, in the next cycle.
  - `cfg_valid` is required again before new beats are accepted.
- Read and write of the same `buf` entry occur in one cycle (read-modify-write). Consecutive beats always address different entries, so no forwarding is needed except for `row_len`=1. In that case the same entry is written in consecutive cycles, and the written value must be forwarded into the next read.

## Configuration
- `PSUM_ACC_SAT_EN`:
  - Defined: every lane add saturates to [-2^(PSUM_W-1), 2^(PSUM_W-1)-1].
  - Undefined: adds wrap modulo 2^PSUM_W.
  - All other behaviour is identical.

## Test plan
- 1x1, `row_len`=4, lanes = beat index, `out_ready`=1 → 4 outputs equal to inputs, 4 `psum_almost_valid` pulses, each one cycle before its `out_valid`.
- 3x3, `row_len`=2, every lane = 10 in all three passes → 2 outputs, every lane 30. `pass_idx` sequence 0,1,2,0.
- 3x3 final pass with `out_ready`=0 for 5 cycles → `in_ready`=0 during the stall, `out_data` stable, no beat lost. The output is released when `out_ready` rises.
- Lane 0 values 30000 + 30000 + 30000 with `PSUM_ACC_SAT_EN` → 32767. Without it → 24464 (wrapped).
- Pass 0 `row_len`=3, pass 1 `in_last` after 2 beats → `err_len`=1, stays 1 until `rst`.
- `rst` asserted mid-pass 1 → next cycle all outputs at reset values. A beat offered without `cfg_valid` is not accepted.
